// File: rtl/alu_logic_shift_unit.sv
// Handshaked logic/shift unit: AND/OR/XOR/NOR in one cycle, shifts/rotate iterate one bit per cycle.
// Define ALU_LOGIC_BARREL_EN to compute shifts/rotate in a single cycle with a barrel shifter instead.
module alu_logic_shift_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x_data,
    input  logic [DATA_W-1:0] in_y_data,
    input  logic [2:0]        logic_fn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_logic_data,
    output logic              out_zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] CNT_ZERO = SHAMT_W'(0);
    localparam logic [DATA_W-1:0]  ACC_ZERO = DATA_W'(0);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_fn;
    logic [1:0]         w_fn_nxt;
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  w_acc_nxt;
    logic [SHAMT_W-1:0] r_cnt;
    logic [SHAMT_W-1:0] w_cnt_nxt;
    logic               r_out_valid;
    logic               r_out_zero;
    logic               w_accept;
    logic [SHAMT_W-1:0] w_amt;

    function automatic logic [DATA_W-1:0] f_logic(input logic [1:0] fn,
                                                  input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
        case (fn)
            2'b00:   f_logic = x & y;
            2'b01:   f_logic = x | y;
            2'b10:   f_logic = x ^ y;
            2'b11:   f_logic = ~(x | y);
            default: f_logic = ACC_ZERO;
        endcase
    endfunction

    // One-bit step of SLL/SRL/SRA/ROR, selected by the low two function bits
    function automatic logic [DATA_W-1:0] f_shift1(input logic [1:0] fn,
                                                   input logic [DATA_W-1:0] a);
        case (fn)
            2'b00:   f_shift1 = {a[DATA_W-2:0], 1'b0};
            2'b01:   f_shift1 = {1'b0, a[DATA_W-1:1]};
            2'b10:   f_shift1 = {a[DATA_W-1], a[DATA_W-1:1]};
            2'b11:   f_shift1 = {a[0], a[DATA_W-1:1]};
            default: f_shift1 = a;
        endcase
    endfunction

`ifdef ALU_LOGIC_BARREL_EN
    function automatic logic [DATA_W-1:0] f_barrel(input logic [1:0] fn,
                                                   input logic [DATA_W-1:0] x,
                                                   input logic [SHAMT_W-1:0] n);
        logic [2*DATA_W-1:0] dbl;
        dbl = {x, x} >> n;
        case (fn)
            2'b00:   f_barrel = x << n;
            2'b01:   f_barrel = x >> n;
            2'b10:   f_barrel = $unsigned($signed(x) >>> n);
            2'b11:   f_barrel = dbl[DATA_W-1:0];
            default: f_barrel = x;
        endcase
    endfunction
`endif

    assign in_ready       = (r_state == S_IDLE) & reset_n;
    assign w_accept       = in_valid & in_ready;
    assign w_amt          = in_y_data[SHAMT_W-1:0];
    assign out_valid      = r_out_valid;
    assign out_logic_data = r_acc;
    assign out_zero       = r_out_zero;

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_fn_nxt    = r_fn;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_fn_nxt  = logic_fn[1:0];
                    w_cnt_nxt = w_amt;
                    if (!logic_fn[2]) begin
                        w_acc_nxt   = f_logic(logic_fn[1:0], in_x_data, in_y_data);
                        w_state_nxt = S_DONE;
                    end
`ifdef ALU_LOGIC_BARREL_EN
                    else begin
                        w_acc_nxt   = f_barrel(logic_fn[1:0], in_x_data, w_amt);
                        w_state_nxt = S_DONE;
                    end
`else
                    else if (w_amt == CNT_ZERO) begin
                        w_acc_nxt   = in_x_data;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_acc_nxt   = in_x_data;
                        w_state_nxt = S_SHIFT;
                    end
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                w_acc_nxt = f_shift1(r_fn, r_acc);
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; flags are registered from the next-state view
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_fn        <= 2'b00;
            r_acc       <= ACC_ZERO;
            r_cnt       <= CNT_ZERO;
            r_out_valid <= 1'b0;
            r_out_zero  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fn        <= w_fn_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= (w_state_nxt == S_DONE);
            r_out_zero  <= (w_state_nxt == S_DONE) && (w_acc_nxt == ACC_ZERO);
        end
    end

endmodule
